// File: rtl/fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// fifo_stream_reader
//
// Read stage placed after a 16-bit synchronous FIFO. It issues FIFO reads,
// absorbs the FIFO's one-cycle read latency, and presents words in FIFO order
// on a valid/ready master stream. A 2-entry skid buffer lets the stream carry
// one word per cycle while m_ready stays high.
//
// Optional feature: define FIFO_STREAM_PARITY_EN to add the m_parity output.
// m_parity is the XOR of m_data. It is computed at capture and stored with
// each buffer entry.
//
// Ports
//   clk         : single clock, rising edge
//   rst_n       : synchronous active-low reset
//   enable      : permits new FIFO reads (words already fetched still drain)
//   fifo_empty  : FIFO empty flag
//   fifo_rd_en  : FIFO read enable (combinational)
//   fifo_data   : FIFO read data, valid one cycle after an accepted read
//   m_valid     : stream word available
//   m_ready     : stream sink accepts the word
//   m_data      : stream word (buffer head)
//   word_cnt    : words delivered on the stream, wraps
//   idle        : buffer empty and no read in flight
//   m_parity    : even parity of m_data (FIFO_STREAM_PARITY_EN only)
// ---------------------------------------------------------------------------
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic                  idle
`ifdef FIFO_STREAM_PARITY_EN
  ,
  output logic                  m_parity
`endif
);

  // The encoding equals the occupancy count. The read-issue arithmetic uses
  // this directly.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL2 = 2'd2
  } occ_e;

  occ_e                  state_q, state_d;
  logic                  inflight_q;
  logic                  wr_idx_q;
  logic                  rd_idx_q;
  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [CNT_WIDTH-1:0]  cnt_q;
`ifdef FIFO_STREAM_PARITY_EN
  logic                  par_q [2];
`endif

  logic       pop;
  logic       capture;
  logic [1:0] occ_cnt;
  logic [2:0] load;

  assign occ_cnt = state_q;
  assign m_valid = (state_q != EMPTY);
  assign pop     = m_valid && m_ready;
  // The FIFO returns data one cycle after an accepted read, so a read issued
  // last cycle is captured at this edge.
  assign capture = inflight_q;

  // Slots committed after this edge. Counting the same-cycle pop keeps full
  // throughput. Keeping this below 2 means the buffer cannot overflow.
  assign load       = {1'b0, occ_cnt} + {2'b00, inflight_q} - {2'b00, pop};
  assign fifo_rd_en = rst_n && enable && !fifo_empty && (load < 3'd2);

  assign m_data   = mem_q[rd_idx_q];
  assign word_cnt = cnt_q;
  assign idle     = (state_q == EMPTY) && !inflight_q;
`ifdef FIFO_STREAM_PARITY_EN
  assign m_parity = par_q[rd_idx_q];
`endif

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statements can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case ({capture, pop})
      2'b10: begin
        unique case (state_q)
          EMPTY:   state_d = ONE;
          ONE:     state_d = FULL2;
          default: state_d = FULL2;
        endcase
      end
      2'b01: begin
        unique case (state_q)
          FULL2:   state_d = ONE;
          ONE:     state_d = EMPTY;
          default: state_d = EMPTY;
        endcase
      end
      default: state_d = state_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments. Every register then
  // samples the pre-edge values of the others, whatever order the
  // statements are in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      inflight_q <= 1'b0;
      wr_idx_q   <= 1'b0;
      rd_idx_q   <= 1'b0;
      cnt_q      <= '0;
      // NOTE: the two buffer entries are reset. m_data shows the head entry
      // and must read 0 out of reset. With only two words the cost is small.
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
`ifdef FIFO_STREAM_PARITY_EN
      par_q[0]   <= 1'b0;
      par_q[1]   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_rd_en;
      if (capture) begin
        mem_q[wr_idx_q] <= fifo_data;
`ifdef FIFO_STREAM_PARITY_EN
        par_q[wr_idx_q] <= ^fifo_data;
`endif
        wr_idx_q        <= ~wr_idx_q;
      end
      if (pop) begin
        rd_idx_q <= ~rd_idx_q;
        cnt_q    <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_stream_reader
//
// Directed bench for fifo_stream_reader. A small FIFO model with a one-cycle
// read latency feeds the block. A negedge monitor records every word popped
// from the stream, and the expected values are written into the bench by
// hand.
// ---------------------------------------------------------------------------
module tb_fifo_stream_reader;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [15:0] fifo_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic [15:0] word_cnt;
  logic        idle;
`ifdef FIFO_STREAM_PARITY_EN
  logic        m_parity;
`endif

  int total = 0;
  int bad   = 0;

  fifo_stream_reader #(.DATA_WIDTH(16), .CNT_WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .word_cnt   (word_cnt),
    .idle       (idle)
`ifdef FIFO_STREAM_PARITY_EN
    ,
    .m_parity   (m_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model. The stimulus writes words and wr_ptr. The model owns rd_ptr.
  // A reset flushes the FIFO, because the FIFO is reset together with the
  // block.
  logic [15:0] fifo_mem [0:511];
  int          wr_ptr = 0;
  int          rd_ptr = 0;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en) begin
      fifo_data <= fifo_mem[rd_ptr[8:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Monitor: inputs change at the negedge. Pops are recorded shortly after,
  // while the values are stable until the next rising edge.
  logic [15:0] out_q [$];
  bit          ovf_seen = 1'b0;

  always @(negedge clk) begin
    #2;
    if (rst_n && m_valid && m_ready) out_q.push_back(m_data);
    if (dut.occ_cnt == 2'd2 && dut.inflight_q) ovf_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] w);
    fifo_mem[wr_ptr[8:0]] = w;
    wr_ptr++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    enable  = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    @(negedge clk); #1;
    while (!idle && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check(tag, idle, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int errs;
    int n;
    bit rd_seen;
    logic [15:0] exp3 [3];
    exp3[0] = 16'hA5A5;
    exp3[1] = 16'h5A5A;
    exp3[2] = 16'h1234;

    rst_n   = 1'b0;
    enable  = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state: with the FIFO non-empty and enable high, reset still
    // blocks reads.
    push(16'hDEAD);
    enable = 1'b1;
    #1;
    check("rst_rd_en",   fifo_rd_en, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data",  m_data, 0);
    check("rst_idle",    idle, 1);
    check("rst_cnt",     word_cnt, 0);
    @(negedge clk);      // the reset edge flushes the FIFO model
    enable = 1'b0;
    rst_n  = 1'b1;

    // T1: preloaded 1..4. Latency is rd_en at N, m_valid at N+2, then one
    // word per cycle.
    @(negedge clk);
    for (int k = 1; k <= 4; k++) push(16'(k));
    m_ready = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    #1;
    check("t1_rd_issue", fifo_rd_en, 1);
    check("t1_idle_pre", idle, 1);
    @(negedge clk); #1;
    check("t1_valid_n1", m_valid, 0);
    @(negedge clk); #1;
    check("t1_word1", {m_valid, m_data}, {1'b1, 16'h0001});
`ifdef FIFO_STREAM_PARITY_EN
    check("t1_par1", m_parity, 1);
`endif
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk); #1;
      check($sformatf("t1_word%0d", k), {m_valid, m_data}, {1'b1, 16'(k)});
`ifdef FIFO_STREAM_PARITY_EN
      if (k == 3) check("t1_par3", m_parity, 0);
`endif
    end
    @(negedge clk); #1;
    check("t1_valid_end", m_valid, 0);
    check("t1_cnt",       word_cnt, 4);
    check("t1_idle",      idle, 1);

    // T2: backpressure. The buffer fills to 2 and reads stop while the head
    // holds stable.
    m_ready = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) push(exp3[k]);
    #1;
    check("t2_rd_issue", fifo_rd_en, 1);
    errs    = 0;
    rd_seen = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk); #1;
      if (i >= 2 && m_data !== 16'hA5A5) errs++;
      if (i >= 2 && fifo_rd_en) rd_seen = 1'b1;
    end
    check("t2_occ_sat",   dut.occ_cnt, 2);
    check("t2_valid",     m_valid, 1);
    check("t2_hold_errs", errs, 0);
    check("t2_no_rd",     rd_seen, 0);
    base    = out_q.size();
    m_ready = 1'b1;
    #1;
    check("t2_resume_rd", fifo_rd_en, 1);
    wait_idle("t2_drain", 20);
    check("t2_count", out_q.size() - base, 3);
    for (int k = 0; k < 3; k++)
      if (out_q.size() > base + k) check($sformatf("t2_order%0d", k), out_q[base + k], exp3[k]);
    check("t2_cnt", word_cnt, 7);

    // T4: enable drops the cycle after a read issue. Only the in-flight word
    // is delivered.
    @(negedge clk);
    push(16'h0BEE);
    push(16'h0CAF);
    #1;
    check("t4_rd_issue", fifo_rd_en, 1);
    base = out_q.size();
    @(negedge clk);
    enable = 1'b0;
    #1;
    check("t4_rd_off", fifo_rd_en, 0);
    rd_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (fifo_rd_en) rd_seen = 1'b1;
    end
    check("t4_no_rd", rd_seen, 0);
    check("t4_idle",  idle, 1);
    check("t4_count", out_q.size() - base, 1);
    if (out_q.size() > base) check("t4_word", out_q[base], 16'h0BEE);
    check("t4_cnt", word_cnt, 8);

    // T3: 200 words under a random m_ready.
    do_reset();
    #1;
    check("t3_cnt_rst", word_cnt, 0);
    enable = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 200; k++) push(16'(k));
    base = out_q.size();
    n    = 0;
    while (out_q.size() - base < 200 && n < 3000) begin
      @(negedge clk);
      m_ready = 1'($urandom_range(0, 1));
      n++;
    end
    m_ready = 1'b1;
    wait_idle("t3_drain", 20);
    check("t3_count", out_q.size() - base, 200);
    errs = 0;
    for (int k = 0; k < 200; k++)
      if (out_q.size() > base + k && out_q[base + k] !== 16'(k)) errs++;
    check("t3_seq_errs", errs, 0);
    check("t3_cnt", word_cnt, 200);

    // T5: reset mid-operation, with one word buffered and one in flight.
    m_ready = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) push(16'h7000 + 16'(k));
    @(negedge clk);
    @(negedge clk); #1;
    check("t5_pre_occ",      dut.occ_cnt, 1);
    check("t5_pre_inflight", dut.inflight_q, 1);
    rst_n = 1'b0;
    #1;
    check("t5_rd_in_rst", fifo_rd_en, 0);
    @(negedge clk); #1;
    check("t5_valid", m_valid, 0);
    check("t5_cnt",   word_cnt, 0);
    check("t5_idle",  idle, 1);
    check("t5_data",  m_data, 0);
    rst_n = 1'b1;

    check("no_ovf_capture", ovf_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
